// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, counter width,
// default bus widths and the wait-counter load helper.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WAIT_CNT_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    // The counter counts the remaining extra cycles after the first one spent in WAIT
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_cycles);
        if (wait_cycles == 0) begin
            return '0;
        end
        return WAIT_CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_bank.sv
// Data RAM bank: one synchronous write port, one asynchronous read port, no reset.
module mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] bank [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            bank[waddr] <= wdata;
        end
    end

    assign rdata = bank[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory port: one load/store at a time with
// a fixed number of wait states and a ready/rvalid handshake.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              m_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
    logic                  cap_w;
    logic [ADDR_W-1:0]     cap_addr;
    logic [DATA_W-1:0]     cap_wdata;

    logic                  accept;
    logic                  go_resp;
    logic                  op_w;
    logic [ADDR_W-1:0]     op_addr;
    logic [DATA_W-1:0]     op_wdata;
    logic                  in_range;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

    assign accept = req && ready && rst_n;

    // With zero wait states the access happens on the accepting edge itself, so the
    // live request fields are used in IDLE and the captured ones afterwards.
    assign op_w     = (state == ST_IDLE) ? m_w   : cap_w;
    assign op_addr  = (state == ST_IDLE) ? addr  : cap_addr;
    assign op_wdata = (state == ST_IDLE) ? wdata : cap_wdata;
    assign in_range = ((op_addr >> IDX_W) == '0);
    assign mem_we   = go_resp && op_w && in_range;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_resp   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = wait_load(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                    go_resp   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            rvalid    <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            cap_w     <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ready  <= (state_nxt == ST_IDLE);
            rvalid <= go_resp;
            err    <= go_resp && !in_range;
            if (accept) begin
                cap_w     <= m_w;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end
            // rdata only moves on a load response so it survives stores and idle cycles
            if (go_resp && !op_w) begin
                rdata <= in_range ? mem_rdata : '0;
            end
        end
    end

    mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (op_addr[IDX_W-1:0]),
        .wdata (op_wdata),
        .raddr (op_addr[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states and one
// with none, checked against hand-computed latencies and data.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req2 = 1'b0;
    logic        req0 = 1'b0;
    logic        m_w = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic        ready2, rvalid2, err2;
    logic [31:0] rdata2;
    logic        ready0, rvalid0, err0;
    logic [31:0] rdata0;

    int checks = 0;
    int errors = 0;
    int rv2_count = 0;
    int rv0_count = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req2), .m_w(m_w), .addr(addr), .wdata(wdata),
        .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .err(err2)
    );

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .m_w(m_w), .addr(addr), .wdata(wdata),
        .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0)
    );

    always @(negedge clk) begin
        if (rvalid2) rv2_count++;
        if (rvalid0) rv0_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One request on the selected instance; returns response latency in cycles after
    // the accepting edge, cycles spent with ready low, and the response fields.
    task automatic applyStimulus(input bit sel, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, output int lat, output int busy,
                                 output logic [31:0] rd, output logic e);
        int  guard;
        bit  found;
        guard = 0;
        @(negedge clk);
        while (!(sel ? ready0 : ready2) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("ready_timeout", 32'd0, 32'd1);
        m_w = w; addr = a; wdata = d;
        if (sel) req0 = 1'b1; else req2 = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b0; req2 = 1'b0;
        lat = 0; busy = 0; rd = '0; e = 1'b0; found = 1'b0;
        while (!found && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!(sel ? ready0 : ready2)) busy++;
            if (sel ? rvalid0 : rvalid2) begin
                found = 1'b1;
                rd = sel ? rdata0 : rdata2;
                e  = sel ? err0 : err2;
            end
        end
        if (!found) checkOutput("rvalid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat, busy, base;
        logic [31:0] rd, snap;
        logic        e;

        $display("[TB] start");

        // Reset held with an active store request pending
        req2 = 1'b1; m_w = 1'b1; addr = 32'd3; wdata = 32'hFFFF_FFFF;
        snap = dut.mem.bank[3];
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(ready2), 32'd1);
        checkOutput("rst_rvalid", 32'(rvalid2), 32'd0);
        checkOutput("rst_rdata", rdata2, 32'd0);
        checkOutput("rst_err", 32'(err2), 32'd0);
        req2 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_bank3", dut.mem.bank[3], snap);

        // Store with two wait states
        applyStimulus(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, busy, rd, e);
        checkOutput("st_latency", 32'(lat), 32'd3);
        checkOutput("st_busy", 32'(busy), 32'd3);
        checkOutput("st_err", 32'(e), 32'd0);
        checkOutput("st_rdata_kept", rd, 32'd0);
        checkOutput("st_bank5", dut.mem.bank[5], 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("st_ready_back", 32'(ready2), 32'd1);
        checkOutput("st_rvalid_pulse", 32'(rvalid2), 32'd0);

        // Loads, including hold of rdata
        applyStimulus(0, 1'b0, 32'd5, 32'd0, lat, busy, rd, e);
        checkOutput("ld_latency", 32'(lat), 32'd3);
        checkOutput("ld_rdata", rd, 32'hDEAD_BEEF);
        checkOutput("ld_err", 32'(e), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("ld_hold", rdata2, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b1, 32'd0, 32'd1, lat, busy, rd, e);
        checkOutput("st0_rdata_kept", rdata2, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, lat, busy, rd, e);
        checkOutput("ld0_rdata", rd, 32'd1);

        // Out-of-range accesses
        applyStimulus(0, 1'b1, 32'd64, 32'd1, lat, busy, rd, e);
        checkOutput("oor_st_err", 32'(e), 32'd1);
        checkOutput("oor_st_latency", 32'(lat), 32'd3);
        checkOutput("oor_st_bank0", dut.mem.bank[0], 32'd1);
        snap = dut.mem.bank[1];
        applyStimulus(0, 1'b1, 32'h41, 32'h0000_0BAD, lat, busy, rd, e);
        checkOutput("oor_st2_err", 32'(e), 32'd1);
        checkOutput("oor_st2_bank1", dut.mem.bank[1], snap);
        applyStimulus(0, 1'b0, 32'h100, 32'd0, lat, busy, rd, e);
        checkOutput("oor_ld_err", 32'(e), 32'd1);
        checkOutput("oor_ld_rdata", rd, 32'd0);
        @(negedge clk);
        checkOutput("oor_err_clear", 32'(err2), 32'd0);
        applyStimulus(0, 1'b0, 32'd5, 32'd0, lat, busy, rd, e);
        checkOutput("ld5_err", 32'(e), 32'd0);
        checkOutput("ld5_rdata", rd, 32'hDEAD_BEEF);

        // Request held continuously for ten edges: accepts on edges 1, 5 and 9
        repeat (3) @(negedge clk);
        base = rv2_count;
        m_w = 1'b0; addr = 32'd5; req2 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        req2 = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("hold_responses", 32'(rv2_count - base), 32'd3);
        checkOutput("hold_rdata", rdata2, 32'hDEAD_BEEF);

        // Reset while a store sits in WAIT
        snap = dut.mem.bank[7];
        base = rv2_count;
        @(negedge clk);
        m_w = 1'b1; addr = 32'd7; wdata = 32'h1234_5678; req2 = 1'b1;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_rvalid", 32'(rv2_count - base), 32'd0);
        checkOutput("abort_ready", 32'(ready2), 32'd1);
        checkOutput("abort_bank7", dut.mem.bank[7], snap);
        applyStimulus(0, 1'b0, 32'd5, 32'd0, lat, busy, rd, e);
        checkOutput("post_abort_latency", 32'(lat), 32'd3);

        // Zero wait states
        applyStimulus(1, 1'b1, 32'd9, 32'hA5A5_A5A5, lat, busy, rd, e);
        checkOutput("w0_st_latency", 32'(lat), 32'd1);
        checkOutput("w0_st_busy", 32'(busy), 32'd1);
        checkOutput("w0_bank9", dut0.mem.bank[9], 32'hA5A5_A5A5);
        applyStimulus(1, 1'b0, 32'd9, 32'd0, lat, busy, rd, e);
        checkOutput("w0_ld_latency", 32'(lat), 32'd1);
        checkOutput("w0_ld_rdata", rd, 32'hA5A5_A5A5);
        repeat (2) @(negedge clk);
        base = rv0_count;
        m_w = 1'b0; addr = 32'd9; req0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w0_b2b_rvalid%0d", i), 32'(rvalid0), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("w0_b2b_count", 32'(rv0_count - base), 32'd3);
        checkOutput("w0_b2b_rdata", rdata0, 32'hA5A5_A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
